led_p2s_ctrl: RTL and testbench
===============================

# led_p2s_ctrl

Serial transmit controller for the LED parallel-to-serial path. Accepts a 16-bit LED pattern with a start pulse, shifts it MSB-first to an external serial-in/parallel-out LED driver with a generated serial clock, then pulses the driver's parallel-latch enable and reports completion. It sits between the display-pattern logic and the board's LED driver pins, replacing hand-driven shift/load control.

## Interface
- `DATA_W`, 16: pattern width, and the number of serial bits sent per frame.
- `CLK_DIV`, 2: number of `clk` cycles per half-period of `led_clk`; must be 1 or more.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request to send a frame; sampled only in IDLE.
- `P_data` in DATA_W: pattern; captured on the edge that accepts `start`.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `led_clk` out 1: serial shift clock to the driver.
- `led_do` out 1: serial data to the driver, MSB first.
- `led_pen` out 1: parallel latch enable to the driver, active-high.
- `led_clrn` out 1: driver clear, active-low.

## Operation
- States: IDLE, SHIFT, LATCH.
- **IDLE:** `led_clk` is 0 and `led_pen` is 0.
  - `start` = 1: capture `P_data` into the shift register, clear `divcnt` and `bitcnt`, go to SHIFT.
- **SHIFT:** `divcnt` counts 0 to 2·CLK_DIV−1 for each bit.
  - `led_clk` = 1 while `divcnt` ≥ CLK_DIV, so the rising edge falls mid-bit.
  - `led_do` = shreg[DATA_W−1], taken directly from a register.
  - At `divcnt` = 2·CLK_DIV−1: shift left by one with zero fill, increment `bitcnt`, and wrap `divcnt` to 0.
  - At the last bit, when `bitcnt` = DATA_W−1 and `divcnt` wraps, go to LATCH.
- **LATCH:** `led_pen` = 1 for 2·CLK_DIV cycles, `led_clk` = 0, `led_do` = 0. Then go to IDLE and assert `done` for one cycle.
- `start` while `busy` is ignored. `P_data` changes after capture have no effect.
- `start` high in the cycle `done` is high: accepted, since the block is already in IDLE. Back-to-back frames have no gap beyond that one cycle.
- `start` held high continuously: frames repeat, each capturing the `P_data` present at its accept edge.
- Widths: `divcnt` is $clog2(2·CLK_DIV) bits; `bitcnt` is $clog2(DATA_W) bits. Neither counter ever exceeds its terminal value.

## Timing
- All outputs are registered. Reset values:
  - `busy` = 0, `done` = 0, `led_clk` = 0, `led_do` = 0, `led_pen` = 0, `led_clrn` = 0.
  - State = IDLE; shreg, `divcnt` and `bitcnt` = 0.
- `led_clrn` goes to 1 on the first edge with `rst` = 0 and stays 1 until the next reset.
- Accept edge = E0:
  - `busy` is 1 from E0 through edge E0 + (DATA_W+1)·2·CLK_DIV.
  - `busy` falls and `done` rises at that same edge; `done` lasts one cycle.
  - CLK_DIV = 2: 68 busy cycles; `done` is high in cycle 68 after E0.
- `led_do` is stable for the full 2·CLK_DIV cycles of each bit: CLK_DIV cycles of setup and CLK_DIV cycles of hold around the `led_clk` rise.
- Exactly DATA_W rising edges of `led_clk` per frame; none in LATCH or IDLE.
- `rst` mid-frame: on the next edge, return to IDLE with reset values. No `done` and no `led_pen` pulse. `led_clrn` goes low, clearing the driver.

## Structure
- Package `led_p2s_pkg` holds:
  - the state enum type (IDLE/SHIFT/LATCH);
  - the default `DATA_W` constant;
  - the function that computes counter widths.
- Sub-module `led_shift_core`: DATA_W-bit parallel-load, left-shift register with ports load, shift, din and msb. The controller FSM and counters instantiate it once.

## Test plan
- Reset: hold `rst` for 3 cycles, then release.
  - During reset: all outputs 0.
  - One edge after release: `led_clrn` = 1, `busy` = 0.
- Basic frame: CLK_DIV = 2, `P_data` = 16'hAA55, one-cycle `start`.
  - `led_do` sampled at the 16 `led_clk` rises reads 1010101001010101.
  - `led_pen` is high for 4 cycles.
  - `done` is high exactly at cycle 68 after E0.
- Busy ignore: `start` pulse 10 cycles into a frame, with `P_data` = 16'hFFFF.
  - The frame is unchanged (still 16'hAA55).
  - Only one `done` is produced.
- Back-to-back: `start` asserted in the `done` cycle with `P_data` = 16'h0001.
  - The second frame begins on that edge.
  - Its serial bits are fifteen 0s then a 1.
- Mid-frame reset: `rst` asserted at cycle 30.
  - The next cycle shows reset values.
  - No `led_pen` and no `done` follow.
  - A fresh 16'h8001 frame then transmits correctly.
- CLK_DIV = 1, `P_data` = 16'h0F0F:
  - `led_clk` toggles every cycle.
  - `done` is high at cycle 34 after E0.

Source files
------------

// File: rtl/led_p2s_pkg.sv
// Shared types and sizing helpers for the LED parallel-to-serial controller.
package led_p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 16;

    // Counter width for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_p2s_ctrl_shift.sv
// Parallel-load, left-shifting register; the MSB drives the serial data pin.
module led_shift_core
    import led_p2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/led_p2s_ctrl.sv
// LED serial transmit controller: shifts a pattern MSB-first with a generated
// serial clock, then pulses the driver latch enable and reports completion.
module led_p2s_ctrl
    import led_p2s_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] P_data,
    output logic              busy,
    output logic              done,
    output logic              led_clk,
    output logic              led_do,
    output logic              led_pen,
    output logic              led_clrn
);

    localparam int DIV_W = cnt_w(2 * CLK_DIV);
    localparam int BIT_W = cnt_w(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t           state, state_n;
    logic [DIV_W-1:0] divcnt, divcnt_n;
    logic [BIT_W-1:0] bitcnt, bitcnt_n;
    logic             load, shift;
    logic             busy_n, done_n, clk_n, pen_n;

    led_shift_core #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (P_data),
        .msb   (led_do)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            divcnt   <= '0;
            bitcnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            led_clk  <= 1'b0;
            led_pen  <= 1'b0;
            led_clrn <= 1'b0;
        end else begin
            state    <= state_n;
            divcnt   <= divcnt_n;
            bitcnt   <= bitcnt_n;
            busy     <= busy_n;
            done     <= done_n;
            led_clk  <= clk_n;
            led_pen  <= pen_n;
            led_clrn <= 1'b1;
        end
    end

    // divcnt paces each bit in SHIFT and is reused to time the latch pulse.
    always_comb begin
        state_n  = state;
        divcnt_n = divcnt;
        bitcnt_n = bitcnt;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    divcnt_n = '0;
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    shift    = 1'b1;
                    if (bitcnt == BIT_LAST) begin
                        bitcnt_n = '0;
                        state_n  = LATCH;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            LATCH: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    state_n  = IDLE;
                end else begin
                    divcnt_n = divcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registers line up with state.
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = (state == LATCH) && (state_n == IDLE);
        clk_n  = (state_n == SHIFT) && (divcnt_n >= DIV_HALF);
        pen_n  = (state_n == LATCH);
    end

endmodule

// File: tb/tb_led_p2s_ctrl.sv
// Directed bench for led_p2s_ctrl with CLK_DIV = 2 and CLK_DIV = 1 instances.
module tb_led_p2s_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] data0 = '0, data1 = '0;
    logic        busy0, done0, lclk0, ldo0, pen0, clrn0;
    logic        busy1, done1, lclk1, ldo1, pen1, clrn1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_p2s_ctrl #(.DATA_W(16), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start0), .P_data(data0),
        .busy(busy0), .done(done0), .led_clk(lclk0), .led_do(ldo0),
        .led_pen(pen0), .led_clrn(clrn0)
    );

    led_p2s_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .P_data(data1),
        .busy(busy1), .done(done1), .led_clk(lclk1), .led_do(ldo1),
        .led_pen(pen1), .led_clrn(clrn1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge (E0), then scramble P_data to show it is not re-read.
    task automatic start_frame(input int which, input logic [15:0] data);
        if (which == 0) begin start0 = 1'b1; data0 = data; end
        else begin start1 = 1'b1; data1 = data; end
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = 16'h1234;
        data1  = 16'h1234;
        check("busy_at_e0", (which == 0) ? busy0 : busy1, 1'b1);
    endtask

    task automatic monitor(input int which, input int max_cyc, input int ign_cyc,
                           input bit b2b, input logic [15:0] b2b_data,
                           output logic [15:0] bits, output int nrise, output int pen_cnt,
                           output int pen_bad, output int done_cyc, output int done_cnt,
                           output int busy_cnt, output int tog_miss);
        logic prev_clk, lc, ld, lp, dn, bs;
        bits = '0; nrise = 0; pen_cnt = 0; pen_bad = 0;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; tog_miss = 0;
        prev_clk = (which == 0) ? lclk0 : lclk1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (which == 0 && c == ign_cyc) begin
                start0 = 1'b1;
                data0  = 16'hFFFF;
            end
            step();
            start0 = 1'b0;
            lc = (which == 0) ? lclk0 : lclk1;
            ld = (which == 0) ? ldo0  : ldo1;
            lp = (which == 0) ? pen0  : pen1;
            dn = (which == 0) ? done0 : done1;
            bs = (which == 0) ? busy0 : busy1;
            if (bs) busy_cnt++;
            if (lc && !prev_clk) begin
                nrise++;
                bits = {bits[14:0], ld};
            end
            if (lp) begin
                pen_cnt++;
                if (lc || ld) pen_bad++;
            end
            if (bs && !lp && c >= 2 && lc == prev_clk) tog_miss++;
            prev_clk = lc;
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (b2b) begin
                    if (which == 0) begin start0 = 1'b1; data0 = b2b_data; end
                    else begin start1 = 1'b1; data1 = b2b_data; end
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [15:0] bits;
        int nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss;

        // Reset held for three cycles
        rst = 1'b1;
        step(); step(); step();
        check("rst_outs0", {busy0, done0, lclk0, ldo0, pen0, clrn0}, 6'b0);
        check("rst_outs1", {busy1, done1, lclk1, ldo1, pen1, clrn1}, 6'b0);
        rst = 1'b0;
        step();
        check("clrn_after_rst0", clrn0, 1'b1);
        check("busy_after_rst0", busy0, 1'b0);
        check("clrn_after_rst1", clrn1, 1'b1);

        // Basic frame AA55
        start_frame(0, 16'hAA55);
        monitor(0, 80, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("basic_bits", bits, 16'hAA55);
        check("basic_rises", nrise, 16);
        check("basic_pen", pen_cnt, 4);
        check("basic_pen_quiet", pen_bad, 0);
        check("basic_done_cyc", done_cyc, 68);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_busy", busy_cnt, 67);

        // Start pulse while busy is ignored
        start_frame(0, 16'hAA55);
        monitor(0, 100, 10, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("ign_bits", bits, 16'hAA55);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_done_cyc", done_cyc, 68);

        // Back-to-back: start in the done cycle
        start_frame(0, 16'hAA55);
        monitor(0, 80, -1, 1'b1, 16'h0001, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("b2b_first_done", done_cyc, 68);
        step();
        start0 = 1'b0;
        data0  = 16'h5A5A;
        check("b2b_second_busy", busy0, 1'b1);
        monitor(0, 80, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("b2b_bits", bits, 16'h0001);
        check("b2b_rises", nrise, 16);
        check("b2b_done_cyc", done_cyc, 68);

        // Mid-frame reset at cycle 30
        start_frame(0, 16'hAA55);
        monitor(0, 29, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("mid_no_done_yet", done_cnt, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_outs", {busy0, done0, lclk0, ldo0, pen0, clrn0}, 6'b0);
        monitor(0, 80, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("mid_no_pen", pen_cnt, 0);
        check("mid_no_done", done_cnt, 0);
        check("mid_no_rise", nrise, 0);
        check("mid_clrn_back", clrn0, 1'b1);
        start_frame(0, 16'h8001);
        monitor(0, 80, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("fresh_bits", bits, 16'h8001);
        check("fresh_done_cyc", done_cyc, 68);

        // CLK_DIV = 1 instance
        start_frame(1, 16'h0F0F);
        monitor(1, 50, -1, 1'b0, 16'h0, bits, nrise, pen_cnt, pen_bad, done_cyc, done_cnt, busy_cnt, tog_miss);
        check("div1_bits", bits, 16'h0F0F);
        check("div1_rises", nrise, 16);
        check("div1_toggle", tog_miss, 0);
        check("div1_pen", pen_cnt, 2);
        check("div1_done_cyc", done_cyc, 34);
        check("div1_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
